// File: rtl/nios2_pio_pkg.sv
// Shared constants for the Nios II parallel-input port: edge modes, register map, width helper.
// Pure package: no logic, no latency, no backpressure.
package nios2_pio_pkg;

    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_ANY     = 2;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_RSVD    = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    // Bits needed to hold the values 0..value-1 (never less than 1).
    function automatic int clog2(input int value);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/nios2_pio_debounce.sv
// One-bit debouncer: v follows s only after s has differed from v for DEBOUNCE_CYCLES cycles.
// Latency DEBOUNCE_CYCLES cycles from a stable change of s; no backpressure.
module nios2_pio_debounce
    import nios2_pio_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic s,
    output logic v
);

    localparam int CW = clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] cnt;

    // Any cycle where s agrees with v restarts the qualification window.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
            v   <= 1'b0;
        end else if (s == v) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
            v   <= s;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/nios2_pio_in_irq.sv
// Avalon-MM parallel input port with synchroniser, edge capture, irq mask; PIO_DEBOUNCE_EN adds per-bit debounce.
// Read latency 1 cycle, edge-to-irq SYNC_STAGES cycles after sampling; always ready, no backpressure.
module nios2_pio_in_irq
    import nios2_pio_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int EDGE_TYPE       = 0,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

`ifdef PIO_DEBOUNCE_EN
    localparam int STARTUP = SYNC_STAGES + DEBOUNCE_CYCLES + 1;
`else
    localparam int STARTUP = SYNC_STAGES + 1;
    localparam int unused_debounce_cycles = DEBOUNCE_CYCLES;
`endif
    localparam int SCW = clog2(STARTUP + 1);
    localparam logic [SCW-1:0] STARTUP_DONE = SCW'(STARTUP);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] v;
    logic [WIDTH-1:0] d_prev;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] irqmask;
    logic [WIDTH-1:0] edgecapture;
    logic [WIDTH-1:0] ecap_clr;
    logic [SCW-1:0]   st_cnt;
    logic             edge_en;
    logic             wr_en;
    logic [31:0]      rd_mux;
    logic             unused_wdata;

    assign unused_wdata = ^writedata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

`ifdef PIO_DEBOUNCE_EN
    for (genvar b = 0; b < WIDTH; b++) begin : g_deb
        nios2_pio_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk    (clk),
            .reset_n(reset_n),
            .s      (s[b]),
            .v      (v[b])
        );
    end
`else
    assign v = s;
`endif

    // Hold off edge detection until the reset-time zeros have flushed out of the pipeline.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st_cnt <= '0;
        end else if (st_cnt != STARTUP_DONE) begin
            st_cnt <= st_cnt + 1'b1;
        end
    end

    assign edge_en = (st_cnt == STARTUP_DONE);

    always_comb begin
        edge_det = '0;
        case (EDGE_TYPE)
            EDGE_RISING:  edge_det = v & ~d_prev;
            EDGE_FALLING: edge_det = ~v & d_prev;
            EDGE_ANY:     edge_det = v ^ d_prev;
            default:      edge_det = v & ~d_prev;
        endcase
        if (!edge_en) begin
            edge_det = '0;
        end
    end

    assign wr_en    = chipselect && !write_n;
    assign ecap_clr = (wr_en && address == ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;

    // A new edge is OR-ed in after the clear so a same-cycle clear cannot drop it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            d_prev      <= '0;
            irqmask     <= '0;
            edgecapture <= '0;
        end else begin
            d_prev      <= v;
            edgecapture <= (edgecapture & ~ecap_clr) | edge_det;
            if (wr_en && address == ADDR_IRQMASK) begin
                irqmask <= writedata[WIDTH-1:0];
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_DATA:    rd_mux[WIDTH-1:0] = v;
            ADDR_RSVD:    rd_mux = '0;
            ADDR_IRQMASK: rd_mux[WIDTH-1:0] = irqmask;
            ADDR_EDGECAP: rd_mux[WIDTH-1:0] = edgecapture;
            default:      rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            readdata <= rd_mux;
        end
    end

    assign irq = |(edgecapture & irqmask);

endmodule

// File: tb/tb_nios2_pio_in_irq.sv
// Scoreboard bench for nios2_pio_in_irq: three instances (rising, falling, any edge) share one bus.
module tb_nios2_pio_in_irq;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'd0;
    logic [7:0]  in_port = 8'd0;
    logic [31:0] rdata [3];
    logic [2:0]  irqv;

    nios2_pio_in_irq #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(0), .DEBOUNCE_CYCLES(16)) dut_rise (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .in_port(in_port), .readdata(rdata[0]), .irq(irqv[0]));
    nios2_pio_in_irq #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(1), .DEBOUNCE_CYCLES(16)) dut_fall (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .in_port(in_port), .readdata(rdata[1]), .irq(irqv[1]));
    nios2_pio_in_irq #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(2), .DEBOUNCE_CYCLES(16)) dut_any (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .in_port(in_port), .readdata(rdata[2]), .irq(irqv[2]));

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          dut;
        logic [31:0] exp_rd;
        logic        exp_irq;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;
    logic rd_req = 1'b0;
    logic rd_req_d;
    logic imm_req = 1'b0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) rd_req_d <= 1'b0;
        else          rd_req_d <= rd_req;
    end

    // Monitor: one expectation is consumed for every presented response.
    always @(negedge clk) begin
        if (rd_req_d || imm_req) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL sb_underflow: response presented with no expectation queued");
            end else begin
                mon_e = sb.pop_front();
                tests++;
                if (rdata[mon_e.dut] !== mon_e.exp_rd) begin
                    fails++;
                    $display("FAIL %s readdata (dut %0d): got %h, expected %h",
                             mon_e.name, mon_e.dut, rdata[mon_e.dut], mon_e.exp_rd);
                end
                tests++;
                if (irqv[mon_e.dut] !== mon_e.exp_irq) begin
                    fails++;
                    $display("FAIL %s irq (dut %0d): got %b, expected %b",
                             mon_e.name, mon_e.dut, irqv[mon_e.dut], mon_e.exp_irq);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic push_exp(input string name, input int dut, input logic [31:0] exp_rd, input logic exp_irq);
        exp_t n;
        n.name    = name;
        n.dut     = dut;
        n.exp_rd  = exp_rd;
        n.exp_irq = exp_irq;
        sb.push_back(n);
    endtask

    // One bus cycle; when chk is set, readdata registered at the next edge and irq after it are checked.
    task automatic op(input string name, input int dut, input logic [1:0] addr, input logic wr,
                      input logic [31:0] wd, input logic chk, input logic [31:0] exp_rd, input logic exp_irq);
        address    = addr;
        chipselect = wr;
        write_n    = !wr;
        writedata  = wd;
        rd_req     = chk;
        if (chk) push_exp(name, dut, exp_rd, exp_irq);
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
        rd_req     = 1'b0;
    endtask

    task automatic chk(input string name, input int dut, input logic [1:0] addr,
                       input logic [31:0] exp_rd, input logic exp_irq);
        op(name, dut, addr, 1'b0, 32'd0, 1'b1, exp_rd, exp_irq);
    endtask

    task automatic wr(input logic [1:0] addr, input logic [31:0] wd);
        op("wr", 0, addr, 1'b1, wd, 1'b0, 32'd0, 1'b0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
`ifdef PIO_DEBOUNCE_EN
        in_port = 8'h00;
        idle(3);
        reset_n = 1'b1;
        chk("rst_data", 0, 2'd0, 32'h0, 1'b0);
        chk("rst_mask", 0, 2'd2, 32'h0, 1'b0);
        chk("rst_rsvd", 0, 2'd1, 32'h0, 1'b0);
        idle(25);
        wr(2'd2, 32'h02);
        chk("mask_rd", 0, 2'd2, 32'h02, 1'b0);
        in_port = 8'h02;
        idle(10);
        in_port = 8'h00;
        idle(25);
        chk("glitch_data", 0, 2'd0, 32'h0, 1'b0);
        chk("glitch_ecap", 0, 2'd3, 32'h0, 1'b0);
        in_port = 8'h02;
        idle(17);
        chk("deb_data_pre", 0, 2'd0, 32'h00, 1'b0);
        chk("deb_data", 0, 2'd0, 32'h02, 1'b1);
        chk("deb_ecap", 0, 2'd3, 32'h02, 1'b1);
`else
        // Startup with inputs held high through reset release.
        in_port = 8'hA5;
        idle(3);
        reset_n = 1'b1;
        chk("startup_r1", 0, 2'd0, 32'h00, 1'b0);
        chk("startup_r2", 0, 2'd0, 32'h00, 1'b0);
        chk("startup_data", 0, 2'd0, 32'hA5, 1'b0);
        chk("startup_ecap_rise", 0, 2'd3, 32'h00, 1'b0);
        chk("startup_ecap_any", 2, 2'd3, 32'h00, 1'b0);
        chk("startup_ecap_fall", 1, 2'd3, 32'h00, 1'b0);
        chk("startup_mask", 0, 2'd2, 32'h00, 1'b0);
        chk("startup_rsvd", 0, 2'd1, 32'h00, 1'b0);

        // Edge, irq latency and clear.
        in_port = 8'h00;
        idle(4);
        wr(2'd3, 32'hFF);
        chk("clr_ecap_any", 2, 2'd3, 32'h00, 1'b0);
        wr(2'd2, 32'h01);
        chk("mask_rd", 0, 2'd2, 32'h01, 1'b0);
        in_port = 8'h01;
        chk("edge_lat1", 0, 2'd3, 32'h00, 1'b0);
        chk("edge_lat2", 0, 2'd3, 32'h00, 1'b0);
        chk("edge_irq", 0, 2'd3, 32'h00, 1'b1);
        chk("edge_ecap", 0, 2'd3, 32'h01, 1'b1);
        op("irq_clr", 0, 2'd3, 1'b1, 32'h01, 1'b1, 32'h01, 1'b0);
        chk("ecap_cleared", 0, 2'd3, 32'h00, 1'b0);

        // Edge and clear landing on the same bit in the same cycle.
        in_port = 8'h09;
        idle(2);
        op("simul_wr", 0, 2'd3, 1'b1, 32'h08, 1'b1, 32'h00, 1'b0);
        chk("simul_ecap", 0, 2'd3, 32'h08, 1'b0);
        op("mask_set", 0, 2'd2, 1'b1, 32'h08, 1'b1, 32'h01, 1'b1);
        op("mask_clr", 0, 2'd2, 1'b1, 32'h00, 1'b1, 32'h08, 1'b0);

        // Falling-edge mode on bit7.
        wr(2'd3, 32'hFF);
        in_port = 8'h89;
        idle(4);
        wr(2'd3, 32'hFF);
        in_port = 8'h09;
        idle(4);
        chk("fall_ecap", 1, 2'd3, 32'h80, 1'b0);
        chk("fall_rise_dut", 0, 2'd3, 32'h00, 1'b0);
        chk("fall_any_dut", 2, 2'd3, 32'h80, 1'b0);

        // Any-edge mode on bit2, both directions.
        wr(2'd3, 32'hFF);
        in_port = 8'h0D;
        idle(4);
        chk("any_rise", 2, 2'd3, 32'h04, 1'b0);
        chk("any_rise_fdut", 1, 2'd3, 32'h00, 1'b0);
        wr(2'd3, 32'h04);
        in_port = 8'h09;
        idle(4);
        chk("any_fall", 2, 2'd3, 32'h04, 1'b0);
        chk("any_fall_rdut", 0, 2'd3, 32'h00, 1'b0);
        wr(2'd0, 32'hFF);
        wr(2'd1, 32'hFF);
        chk("data_ro", 0, 2'd0, 32'h09, 1'b0);
        chk("rsvd_ro", 0, 2'd1, 32'h00, 1'b0);

        // Asynchronous reset mid-run with capture and mask fully set.
        wr(2'd3, 32'hFF);
        wr(2'd2, 32'hFF);
        in_port = 8'hF6;
        idle(4);
        chk("pre_rst_ecap", 2, 2'd3, 32'hFF, 1'b1);
        idle(1);
        reset_n = 1'b0;
        address = 2'd3;
        imm_req = 1'b1;
        push_exp("rst_immediate", 2, 32'h00, 1'b0);
        @(negedge clk);
        #1;
        imm_req = 1'b0;
        idle(2);
        reset_n = 1'b1;
        chk("rst_data", 0, 2'd0, 32'h00, 1'b0);
        chk("rst_ecap", 2, 2'd3, 32'h00, 1'b0);
        chk("rst_mask", 2, 2'd2, 32'h00, 1'b0);
        idle(3);
        chk("rst_nospur", 2, 2'd3, 32'h00, 1'b0);
`endif
        idle(2);
        if (sb.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL sb_drain: %0d expectations left, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/nios2_pio_in_irq.md
Name: nios2_pio_in_irq

Overview:
Parametrised Avalon-MM slave input port for the Nios II system: generic-width parallel input with synchroniser, per-bit edge capture, interrupt mask and IRQ output. Successor to our fixed 8-bit read-only PIO inputs (switch and PV-select style). Sits on the Nios II data master interconnect; irq goes to the CPU interrupt controller.

Parameters:
WIDTH, 8, input port width, legal 1..32
SYNC_STAGES, 2, metastability flops on in_port, legal 2..4
EDGE_TYPE, 0, 0 = rising, 1 = falling, 2 = any edge
DEBOUNCE_CYCLES, 16, stable cycles required before the debounced value changes (used only with PIO_DEBOUNCE_EN), legal 2..65535

Ports:
clk  in  1  system clock
reset_n  in  1  reset, asynchronous, active-low
address  in  2  Avalon word address
chipselect  in  1  Avalon slave select
write_n  in  1  Avalon write strobe, active-low
writedata  in  32  Avalon write data
in_port  in  WIDTH  asynchronous external inputs
readdata  out  32  Avalon read data, registered
irq  out  1  interrupt request, active-high, level

Behaviour:
- Reset and async behaviour: reset_n low clears all flops immediately (sync chain, debounce state, d_prev, irqmask, edgecapture, startup counter, readdata). readdata = 0 and irq = 0 in reset.
- Synchroniser: in_port passes through SYNC_STAGES flops per bit. Output s = the sampled value. With PIO_DEBOUNCE_EN, the debounced value is used instead of s. Call this value v.
- Register map (word addresses, zero-extended to 32 b):
  - 0 DATA: v, read-only.
  - 1: reserved, reads 0.
  - 2 IRQMASK: read/write, low WIDTH bits.
  - 3 EDGECAPTURE: read; a write clears the bits where writedata = 1.
- Write qualification: a write occurs when chipselect = 1 and write_n = 0. Writes to addresses 0 and 1 are ignored. Bits of writedata at or above WIDTH are ignored.
- Reads: readdata is re-registered every clk from the address mux. There is no read strobe. Read latency is 1 cycle and there are no read side effects.
- Edge detect:
  - d_prev <= v every cycle.
  - Rising = v & ~d_prev; falling = ~v & d_prev; any = v ^ d_prev, selected by EDGE_TYPE.
- Edge capture:
  - edgecapture[i] is set on a detected edge.
  - It is cleared by a write to address 3 with writedata[i] = 1.
  - If an edge and a clear hit the same bit in the same cycle, set wins and the edge is not lost.
  - Bits are sticky until cleared.
- Startup gate: a counter runs from reset release. Edge detection is suppressed until SYNC_STAGES+1 cycles have elapsed, or SYNC_STAGES+DEBOUNCE_CYCLES+1 with PIO_DEBOUNCE_EN. Inputs held high out of reset therefore do not create spurious edges. The counter saturates and never wraps.
- irq = |(edgecapture & irqmask), derived from registered state only, with no added latency.
- Latency, no debounce, SYNC_STAGES = 2. in_port changes before clk edge n:
  - s is valid after edge n+1.
  - edgecapture and irq update at edge n+2.
  - readdata reflects the change at edge n+2 for DATA and n+3 for EDGECAPTURE.
- IRQ clear: clearing the last masked capture bit deasserts irq in the cycle after the write. Masking a set bit deasserts irq in the cycle after the IRQMASK write.

Optional Feature:
PIO_DEBOUNCE_EN
- Defined: a per-bit debouncer sits between s and v. A per-bit counter increments while s differs from v. v toggles when the count reaches DEBOUNCE_CYCLES. The counter resets to 0 whenever s equals v. Glitches shorter than DEBOUNCE_CYCLES are rejected, and the DATA and edge latency grows by DEBOUNCE_CYCLES.
- Undefined: v = s. No counters are synthesised.

Decomposition:
- Package nios2_pio_pkg:
  - EDGE_RISING = 0, EDGE_FALLING = 1, EDGE_ANY = 2.
  - Register address constants ADDR_DATA = 0, ADDR_RSVD = 1, ADDR_IRQMASK = 2, ADDR_EDGECAP = 3.
  - Counter width function clog2.
- Sub-module nios2_pio_debounce: 1-bit debouncer, instantiated per bit in a generate loop under PIO_DEBOUNCE_EN.

Test Plan:
All scenarios use WIDTH = 8, SYNC_STAGES = 2, EDGE_TYPE = 0 unless stated.
- Reset/idle: assert reset_n = 0 mid-run with edgecapture = 0xFF and irqmask = 0xFF -> readdata = 0 and irq = 0 immediately; all registers read 0 after release.
- Startup: in_port = 0xA5 held through reset release -> DATA reads 0xA5 after 3 cycles; EDGECAPTURE stays 0x00 and irq stays 0.
- Edge + IRQ: mask = 0x01; in_port bit0 goes 0->1 -> EDGECAPTURE = 0x01 and irq = 1 two cycles later. Write 0x01 to address 3 -> irq = 0 the next cycle.
- Simultaneous: a rising edge on bit3 in the same cycle as a clear write of 0x08 -> EDGECAPTURE bit3 remains 1.
- Modes: EDGE_TYPE = 1, a 1->0 transition on bit7 -> capture 0x80. EDGE_TYPE = 2, a 0->1->0 transition on bit2 -> capture set on both transitions; a write to address 0 of 0xFF -> DATA unchanged.
- Debounce (PIO_DEBOUNCE_EN, DEBOUNCE_CYCLES = 16): a 10-cycle pulse on bit1 -> DATA and capture unchanged. A 20-cycle pulse -> DATA bit1 = 1 at 2+16 cycles after the input change, and a capture follows.
